// File: rtl/avr_intc.sv
// AVR-style 8-line interrupt controller: synchronised rising-edge detection,
// fixed-priority dispatch (bit 0 highest), and a MASK/PEND/EOI/STAT register window.
module avr_intc #(
  parameter logic [15:0] BASE = 16'h0020
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  irq,
  input  logic [15:0] address,
  input  logic [7:0]  wdata,
  input  logic        we,
  output logic [7:0]  rdata,
  output logic        intr,
  output logic [2:0]  vect
);

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  sync1;
  logic [7:0]  sync2;
  logic [7:0]  prev;
  logic [7:0]  mask;
  logic [7:0]  pend;
  logic [7:0]  edges;
  logic [7:0]  req;
  logic [7:0]  pend_next;
  logic [7:0]  rdata_next;
  logic [15:0] offset;
  logic        hit;
  logic        wr_mask;
  logic        wr_pend;
  logic        wr_eoi;
  logic        dispatch;
  logic [2:0]  sel;

  // Offset wraps for addresses below BASE, so only BASE..BASE+3 give a zero upper part.
  assign offset  = address - BASE;
  assign hit     = (offset[15:2] == 14'd0);
  assign wr_mask = we & hit & (offset[1:0] == 2'd0);
  assign wr_pend = we & hit & (offset[1:0] == 2'd1);
  assign wr_eoi  = we & hit & (offset[1:0] == 2'd2);

  assign edges = sync2 & ~prev;
  assign req   = pend & mask;

  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) sel = 3'(i);
    end
  end

  always_comb begin
    state_next = state;
    dispatch   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          dispatch   = 1'b1;
          state_next = SERVICE;
        end
      end
      SERVICE: begin
        if (wr_eoi) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A newly detected edge is OR-ed in last so it beats both dispatch and write-1-clear.
  always_comb begin
    pend_next = pend;
    if (dispatch) pend_next[sel] = 1'b0;
    if (wr_pend)  pend_next = pend_next & ~wdata;
    pend_next = pend_next | edges;
  end

  always_comb begin
    rdata_next = 8'h00;
    if (hit) begin
      case (offset[1:0])
        2'd0:    rdata_next = mask;
        2'd1:    rdata_next = pend;
        2'd3:    rdata_next = {(state == SERVICE), 4'b0000, vect};
        default: rdata_next = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
      prev  <= 8'h00;
    end else begin
      sync1 <= irq;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask  <= 8'h00;
      pend  <= 8'h00;
      rdata <= 8'h00;
      intr  <= 1'b0;
      vect  <= 3'd0;
    end else begin
      if (wr_mask) mask <= wdata;
      pend  <= pend_next;
      rdata <= rdata_next;
      intr  <= dispatch;
      if (dispatch) vect <= sel;
    end
  end

endmodule

// File: tb/tb_avr_intc.sv
// Bench for avr_intc: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the controller's register/dispatch rules.
module tb_avr_intc;

  localparam logic [15:0] BASE = 16'h0020;

  logic        clock;
  logic        reset;
  logic [7:0]  irq;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic        we;
  logic [7:0]  rdata;
  logic        intr;
  logic [2:0]  vect;

  int n_checks = 0;
  int n_fail   = 0;

  avr_intc #(.BASE(BASE)) dut (
    .clock   (clock),
    .reset   (reset),
    .irq     (irq),
    .address (address),
    .wdata   (wdata),
    .we      (we),
    .rdata   (rdata),
    .intr    (intr),
    .vect    (vect)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model: h1..h3 are the irq values seen at the last three edges;
  // a line counts as risen when it was seen high two edges ago after being low.
  typedef struct packed {
    logic [7:0] mask;
    logic [7:0] pend;
    logic       busy;
    logic [2:0] vect;
    logic       intr;
    logic [7:0] rdata;
    logic [7:0] h1;
    logic [7:0] h2;
    logic [7:0] h3;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t c, logic [7:0] irq_s, logic [15:0] a,
                                        logic [7:0] d, logic w);
    model_t n = c;
    int off = int'(a) - int'(BASE);
    int pick = -1;
    n.intr = 1'b0;
    if (off >= 0 && off <= 3) begin
      case (off)
        0: n.rdata = c.mask;
        1: n.rdata = c.pend;
        3: n.rdata = {c.busy, 4'b0000, c.vect};
        default: n.rdata = 8'h00;
      endcase
    end else begin
      n.rdata = 8'h00;
    end
    if (!c.busy) begin
      for (int i = 7; i >= 0; i--) if (c.pend[i] && c.mask[i]) pick = i;
    end
    if (pick >= 0) begin
      n.intr = 1'b1;
      n.vect = 3'(pick);
      n.busy = 1'b1;
      n.pend[pick] = 1'b0;
    end
    if (w && off == 0) n.mask = d;
    if (w && off == 1) n.pend = n.pend & ~d;
    if (w && off == 2 && c.busy) n.busy = 1'b0;
    n.pend = n.pend | (c.h2 & ~c.h3);
    n.h3 = c.h2;
    n.h2 = c.h1;
    n.h1 = irq_s;
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m <= '0;
    else       m <= model_next(m, irq, address, wdata, we);
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    address = a;
    wdata   = d;
    we      = 1'b1;
    tick();
    we      = 1'b0;
    address = 16'h0000;
  endtask

  task automatic do_reset();
    irq     = 8'h00;
    we      = 1'b0;
    address = 16'h0000;
    wdata   = 8'h00;
    reset   = 1'b1;
    tick();
    tick();
    reset   = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    irq = 8'h00; we = 1'b0; address = 16'h0000; wdata = 8'h00;
    reset = 1'b1;
    #1;
    n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr: got %b want 0", intr); end
    n_checks++; if (vect !== 3'd0) begin n_fail++; $display("FAIL reset_vect: got %0d want 0", vect); end
    n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    tick();
    reset = 1'b0;
    address = BASE;     tick();
    n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_mask: got %h want 00", rdata); end
    address = BASE + 1; tick();
    n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_pend: got %h want 00", rdata); end
    address = BASE + 3; tick();
    n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_stat: got %h want 00", rdata); end
    address = 16'h0000;
  endtask

  task automatic test_basic();
    do_reset();
    bus_write(BASE, 8'h04);
    irq = 8'h04;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL basic_early_intr: cycle %0d got %b want 0", k, intr); end
    end
    address = BASE + 1;
    tick();
    n_checks++; if (intr !== 1'b1) begin n_fail++; $display("FAIL basic_intr: got %b want 1", intr); end
    n_checks++; if (vect !== 3'd2) begin n_fail++; $display("FAIL basic_vect: got %0d want 2", vect); end
    n_checks++; if (rdata !== 8'h04) begin n_fail++; $display("FAIL basic_pend_set: got %h want 04", rdata); end
    address = BASE + 3;
    tick();
    n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_len: got %b want 0", intr); end
    n_checks++; if (rdata !== 8'h82) begin n_fail++; $display("FAIL basic_stat: got %h want 82", rdata); end
    address = BASE + 1;
    tick();
    n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL basic_pend_clr: got %h want 00", rdata); end
    irq = 8'h00;
    bus_write(BASE + 2, 8'h5a);
    address = BASE + 3;
    tick();
    n_checks++; if (rdata !== 8'h02) begin n_fail++; $display("FAIL basic_stat_idle: got %h want 02", rdata); end
    address = 16'h0000;
  endtask

  task automatic test_priority();
    do_reset();
    bus_write(BASE, 8'hff);
    irq = 8'h22;
    repeat (3) tick();
    tick();
    n_checks++; if (intr !== 1'b1 || vect !== 3'd1) begin n_fail++; $display("FAIL prio_first: got intr=%b vect=%0d want 1/1", intr, vect); end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL prio_hold: got %b want 0", intr); end
    end
    address = BASE + 2; we = 1'b1;
    tick();
    we = 1'b0; address = 16'h0000;
    n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL prio_eoi_edge: got %b want 0", intr); end
    tick();
    n_checks++; if (intr !== 1'b1 || vect !== 3'd5) begin n_fail++; $display("FAIL prio_second: got intr=%b vect=%0d want 1/5", intr, vect); end
    tick();
    n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL prio_no_double: got %b want 0", intr); end
    irq = 8'h00;
  endtask

  task automatic test_masked();
    do_reset();
    irq = 8'h08;
    repeat (4) tick();
    n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL masked_intr: got %b want 0", intr); end
    address = BASE + 1;
    tick();
    n_checks++; if (rdata !== 8'h08) begin n_fail++; $display("FAIL masked_pend: got %h want 08", rdata); end
    bus_write(BASE, 8'h08);
    n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL masked_write_edge: got %b want 0", intr); end
    tick();
    n_checks++; if (intr !== 1'b1 || vect !== 3'd3) begin n_fail++; $display("FAIL masked_unmask: got intr=%b vect=%0d want 1/3", intr, vect); end
    irq = 8'h00;
  endtask

  task automatic test_reentry();
    do_reset();
    bus_write(BASE, 8'h01);
    irq = 8'h01;
    repeat (4) tick();
    n_checks++; if (intr !== 1'b1 || vect !== 3'd0) begin n_fail++; $display("FAIL reentry_first: got intr=%b vect=%0d want 1/0", intr, vect); end
    irq = 8'h00;
    repeat (2) tick();
    irq = 8'h01;
    repeat (3) tick();
    address = BASE + 1;
    tick();
    n_checks++; if (rdata !== 8'h01) begin n_fail++; $display("FAIL reentry_pend: got %h want 01", rdata); end
    n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL reentry_blocked: got %b want 0", intr); end
    address = BASE + 3;
    tick();
    n_checks++; if (rdata !== 8'h80) begin n_fail++; $display("FAIL reentry_stat: got %h want 80", rdata); end
    bus_write(BASE + 2, 8'h00);
    n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL reentry_eoi_edge: got %b want 0", intr); end
    tick();
    n_checks++; if (intr !== 1'b1 || vect !== 3'd0) begin n_fail++; $display("FAIL reentry_again: got intr=%b vect=%0d want 1/0", intr, vect); end
    irq = 8'h00;
  endtask

  task automatic test_w1c();
    do_reset();
    irq = 8'h10;
    repeat (4) tick();
    irq = 8'h00;
    repeat (3) tick();
    irq = 8'h10;
    repeat (2) tick();
    address = BASE + 1; wdata = 8'h10; we = 1'b1;
    tick();
    we = 1'b0;
    tick();
    n_checks++; if (rdata !== 8'h10) begin n_fail++; $display("FAIL w1c_set_wins: got %h want 10", rdata); end
    bus_write(BASE + 1, 8'h10);
    address = BASE + 1;
    tick();
    n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL w1c_clear: got %h want 00", rdata); end
    address = 16'hbeef; wdata = 8'hff; we = 1'b1;
    tick();
    we = 1'b0; address = BASE;
    tick();
    n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL outside_write: got %h want 00", rdata); end
    irq = 8'h00; address = 16'h0000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_write(BASE, 8'hff);
    irq = 8'h07;
    repeat (4) tick();
    n_checks++; if (intr !== 1'b1 || vect !== 3'd0) begin n_fail++; $display("FAIL midrst_dispatch: got intr=%b vect=%0d want 1/0", intr, vect); end
    irq = 8'h00;
    reset = 1'b1;
    #1;
    n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL midrst_intr: got %b want 0", intr); end
    n_checks++; if (vect !== 3'd0) begin n_fail++; $display("FAIL midrst_vect: got %0d want 0", vect); end
    tick();
    reset = 1'b0;
    address = BASE + 3; tick();
    n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL midrst_stat: got %h want 00", rdata); end
    address = BASE + 1; tick();
    n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL midrst_pend: got %h want 00", rdata); end
    address = BASE;     tick();
    n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL midrst_mask: got %h want 00", rdata); end
    address = 16'h0000;
  endtask

  task automatic test_held_reset();
    irq = 8'h01; we = 1'b0; address = 16'h0000;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL held_masked: got %b want 0", intr); end
    address = BASE + 1;
    tick();
    n_checks++; if (rdata !== 8'h01) begin n_fail++; $display("FAIL held_pend: got %h want 01", rdata); end
    bus_write(BASE, 8'h01);
    tick();
    n_checks++; if (intr !== 1'b1 || vect !== 3'd0) begin n_fail++; $display("FAIL held_dispatch: got intr=%b vect=%0d want 1/0", intr, vect); end
    bus_write(BASE + 2, 8'h00);
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (intr !== 1'b0) begin n_fail++; $display("FAIL held_once: got %b want 0", intr); end
    end
    irq = 8'h00;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
      we = 1'b0;
      wdata = 8'($urandom);
      case ($urandom_range(0, 7))
        0, 1: address = BASE + 16'($urandom_range(0, 3));
        2: begin address = BASE;     we = 1'b1; end
        3: begin address = BASE + 1; we = 1'b1; end
        4, 5: begin address = BASE + 2; we = 1'b1; end
        6: begin address = ($urandom_range(0, 1) == 0) ? BASE - 1 : BASE + 4; we = 1'b1; end
        default: address = 16'($urandom);
      endcase
      tick();
      n_checks++; if (intr !== m.intr) begin n_fail++; $display("FAIL rand_intr: cycle %0d got %b want %b", k, intr, m.intr); end
      n_checks++; if (vect !== m.vect) begin n_fail++; $display("FAIL rand_vect: cycle %0d got %0d want %0d", k, vect, m.vect); end
      n_checks++; if (rdata !== m.rdata) begin n_fail++; $display("FAIL rand_rdata: cycle %0d addr %h got %h want %h", k, address, rdata, m.rdata); end
    end
    we = 1'b0; address = 16'h0000; irq = 8'h00;
  endtask

  initial begin
    reset = 1'b1; irq = 8'h00; address = 16'h0000; wdata = 8'h00; we = 1'b0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_priority();
    test_masked();
    test_reentry();
    test_w1c();
    test_reset_mid();
    test_held_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
